// File: rtl/reply_framer_pkg.sv
// Shared definitions for the reply framer: FSM states, default sizing and
// the header LEN helper.
package reply_framer_pkg;

  // Largest payload per packet; LEN = payload + 1 must still fit in a byte.
  localparam int MAX_LEN_DEF = 254;
  // Buffer address width; 2**AW_DEF must cover MAX_LEN_DEF.
  localparam int AW_DEF      = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CAPTURE  = 3'd1,
    ST_HDR_LEN  = 3'd2,
    ST_HDR_MASK = 3'd3,
    ST_PAYLOAD  = 3'd4
  } state_e;

  // LEN byte of the header: stored payload count plus one for the mask byte.
  function automatic logic [7:0] len_byte(input logic [7:0] cnt);
    return cnt + 8'd1;
  endfunction

endpackage

// File: rtl/reply_framer_if.sv
// Target-side reply bus and outbound FIFO write port of the reply framer.
//
// Handshakes: a source byte moves on any cycle where src_valid and src_ready
// are both high (src_last and src_mask are only meaningful on such a cycle).
// Toward the FIFO, one byte is written on every cycle reply_wr is high; the
// framer never raises reply_wr while reply_full is high and holds reply_data
// steady until the byte is written.
interface reply_framer_if;
  logic [7:0] src_mask;
  logic [7:0] src_data;
  logic       src_valid;
  logic       src_last;
  logic       src_ready;
  logic [7:0] reply_data;
  logic       reply_wr;
  logic       reply_full;

  // Traffic generator / FIFO model side.
  modport master (
    output src_mask, src_data, src_valid, src_last, reply_full,
    input  src_ready, reply_data, reply_wr
  );

  // Framer side.
  modport slave (
    input  src_mask, src_data, src_valid, src_last, reply_full,
    output src_ready, reply_data, reply_wr
  );
endinterface

// File: rtl/reply_framer_buf.sv
// reply_buf: simple dual-port payload RAM, one write port and a registered
// read port on a single clock. No reset so it maps onto block RAM.
module reply_buf #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [2**AW];
  logic [7:0] rdata_q;

  // Synchronous write and registered read.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/reply_framer.sv
// reply_framer: buffers a reply packet from an on-chip target, then emits
// LEN, source mask and payload to the outbound FX2 FIFO.
module reply_framer
  import reply_framer_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int AW      = AW_DEF
) (
  input  logic           clk,
  input  logic           reset_n,
  reply_framer_if.slave  bus,
  output logic           busy,
  output logic           overflow,
  output state_e         dbg_state
);

  localparam logic [AW:0] MAX_CNT = (AW+1)'(MAX_LEN);
  localparam logic [AW:0] ONE     = (AW+1)'(1);

  state_e        state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [7:0]    mask_q, mask_d;
  logic          ovf_q, ovf_d;
  logic          rdy_en_q;

  logic          xfer;
  logic          emit;
  logic          wr;
  logic          buf_we;
  logic [AW-1:0] buf_waddr;
  logic [7:0]    buf_rdata;
  logic [7:0]    data;

  // Source side is open only while collecting, and never during reset.
  assign bus.src_ready = rdy_en_q & ((state_q == ST_IDLE) | (state_q == ST_CAPTURE));
  assign xfer          = bus.src_valid & bus.src_ready;
  assign emit          = (state_q == ST_HDR_LEN) | (state_q == ST_HDR_MASK) |
                         (state_q == ST_PAYLOAD);
  assign wr            = emit & ~bus.reply_full;

  // The RAM reads the next pointer value, so its output always reflects rd_q;
  // that acts as a prefetch and lets payload bytes stream back-to-back.
  reply_buf #(.AW(AW)) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (buf_waddr),
    .wdata (bus.src_data),
    .raddr (rd_d),
    .rdata (buf_rdata)
  );

  // Next-state, counters, buffer write and emitted byte.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    mask_d    = mask_q;
    ovf_d     = ovf_q;
    buf_we    = 1'b0;
    buf_waddr = cnt_q[AW-1:0];
    data      = 8'h00;
    unique case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          mask_d    = bus.src_mask;
          buf_we    = 1'b1;
          buf_waddr = '0;
          cnt_d     = ONE;
          ovf_d     = 1'b0;
          rd_d      = '0;
          state_d   = bus.src_last ? ST_HDR_LEN : ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (xfer) begin
          // Past MAX_LEN bytes are still accepted but dropped.
          if (cnt_q < MAX_CNT) begin
            buf_we = 1'b1;
            cnt_d  = cnt_q + ONE;
          end else begin
            ovf_d = 1'b1;
          end
          if (bus.src_last) state_d = ST_HDR_LEN;
        end
      end
      ST_HDR_LEN: begin
        data = len_byte(cnt_q[7:0]);
        if (wr) state_d = ST_HDR_MASK;
      end
      ST_HDR_MASK: begin
        data = mask_q;
        if (wr) state_d = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        data = buf_rdata;
        if (wr) begin
          if ({1'b0, rd_q} == cnt_q - ONE) begin
            rd_d    = '0;
            state_d = ST_IDLE;
          end else begin
            rd_d = rd_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rd_q     <= '0;
      mask_q   <= 8'h00;
      ovf_q    <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      mask_q   <= mask_d;
      ovf_q    <= ovf_d;
      rdy_en_q <= 1'b1;
    end
  end

  assign bus.reply_wr   = wr;
  assign bus.reply_data = data;
  assign busy           = (state_q != ST_IDLE);
  assign overflow       = ovf_q;
  assign dbg_state      = state_q;

endmodule
